// File: rtl/axis_packet_tx.sv
// AXI4-Stream packet transmitter: data FIFO plus descriptor-driven framing FSM.
// Optional macro AXIS_TX_STATS_EN adds pkt/beat/stall counters.
module axis_packet_tx #(
  parameter int DATA_WIDTH   = 2,
  parameter int TDEST_WIDTH  = 4,
  parameter int TID_WIDTH    = 2,
  parameter int TUSER_WIDTH  = 2,
  parameter int BUFFER_DEPTH = 64,
  parameter int LEN_WIDTH    = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wr_en,
  input  logic [DATA_WIDTH*8-1:0]               wr_data,
  output logic                                  wr_full,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]     fifo_level,
  output logic                                  err_overflow,
  input  logic                                  desc_valid,
  output logic                                  desc_ready,
  input  logic [TDEST_WIDTH-1:0]                desc_dest,
  input  logic [TID_WIDTH-1:0]                  desc_id,
  input  logic [TUSER_WIDTH-1:0]                desc_user,
  input  logic [LEN_WIDTH-1:0]                  desc_len,
  output logic [DATA_WIDTH*8-1:0]               m_axis_tdata,
  output logic [TDEST_WIDTH-1:0]                m_axis_tdest,
  output logic [TID_WIDTH-1:0]                  m_axis_tid,
  output logic [TUSER_WIDTH-1:0]                m_axis_tuser,
  output logic                                  m_axis_tvalid,
  output logic                                  m_axis_tlast,
  input  logic                                  m_axis_tready
`ifdef AXIS_TX_STATS_EN
  ,
  output logic [31:0]                           pkt_count,
  output logic [31:0]                           beat_count,
  output logic [31:0]                           stall_count
`endif
);
  localparam int DW  = DATA_WIDTH * 8;
  localparam int AW  = $clog2(BUFFER_DEPTH);
  localparam int LVW = $clog2(BUFFER_DEPTH + 1);
  localparam int CW  = LEN_WIDTH + 1;

  typedef enum logic {IDLE, SEND} state_t;

  logic [DW-1:0]          mem_q [BUFFER_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [LVW-1:0]         level_q, level_d;
  logic                   err_q;
  logic                   full, empty, push, pop, owed;

  state_t                 state_q;
  logic                   desc_ready_q;
  logic [TDEST_WIDTH-1:0] dest_q;
  logic [TID_WIDTH-1:0]   id_q;
  logic [TUSER_WIDTH-1:0] user_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [CW-1:0]          cnt_q;
  logic [DW-1:0]          tdata_q;
  logic                   tvalid_q, tlast_q;

  always_comb begin
    full    = (level_q == LVW'(BUFFER_DEPTH));
    empty   = (level_q == '0);
    push    = wr_en & ~full;
    owed    = (cnt_q <= {1'b0, len_q});
    // The output register can take a new beat when empty or being drained now
    pop     = (state_q == SEND) & (~tvalid_q | m_axis_tready) & ~empty & owed;
    level_d = level_q + LVW'(push) - LVW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      if (wr_en & full) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      desc_ready_q <= 1'b0;
      dest_q       <= '0;
      id_q         <= '0;
      user_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          desc_ready_q <= 1'b1;
          if (desc_valid & desc_ready_q) begin
            dest_q       <= desc_dest;
            id_q         <= desc_id;
            user_q       <= desc_user;
            len_q        <= desc_len;
            cnt_q        <= '0;
            desc_ready_q <= 1'b0;
            state_q      <= SEND;
          end
        end
        SEND: begin
          if (pop) begin
            tdata_q  <= mem_q[rd_ptr_q];
            tvalid_q <= 1'b1;
            tlast_q  <= (cnt_q == {1'b0, len_q});
            cnt_q    <= cnt_q + CW'(1);
          end else if (tvalid_q & m_axis_tready) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            if (tlast_q) begin
              state_q      <= IDLE;
              desc_ready_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_full       = full;
  assign fifo_level    = level_q;
  assign err_overflow  = err_q;
  assign desc_ready    = desc_ready_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tdest  = dest_q;
  assign m_axis_tid    = id_q;
  assign m_axis_tuser  = user_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

`ifdef AXIS_TX_STATS_EN
  logic [31:0] pkt_q, beat_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_q   <= '0;
      beat_q  <= '0;
      stall_q <= '0;
    end else begin
      if (tvalid_q & m_axis_tready)            beat_q  <= beat_q + 32'd1;
      if (tvalid_q & m_axis_tready & tlast_q)  pkt_q   <= pkt_q + 32'd1;
      if (tvalid_q & ~m_axis_tready)           stall_q <= stall_q + 32'd1;
    end
  end

  assign pkt_count   = pkt_q;
  assign beat_count  = beat_q;
  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_axis_packet_tx.sv
// Scoreboard bench for axis_packet_tx: stimulus queues expected beats, a
// negedge monitor pops and compares each handshake and checks hold stability.
module tb_axis_packet_tx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_full;
  logic [6:0]  fifo_level;
  logic        err_overflow;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [3:0]  desc_dest = '0;
  logic [1:0]  desc_id = '0;
  logic [1:0]  desc_user = '0;
  logic [7:0]  desc_len = '0;
  logic [15:0] m_axis_tdata;
  logic [3:0]  m_axis_tdest;
  logic [1:0]  m_axis_tid;
  logic [1:0]  m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;
`ifdef AXIS_TX_STATS_EN
  logic [31:0] pkt_count, beat_count, stall_count;
`endif

  axis_packet_tx dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .fifo_level(fifo_level), .err_overflow(err_overflow),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_dest(desc_dest),
    .desc_id(desc_id), .desc_user(desc_user), .desc_len(desc_len),
    .m_axis_tdata(m_axis_tdata), .m_axis_tdest(m_axis_tdest), .m_axis_tid(m_axis_tid),
    .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
`ifdef AXIS_TX_STATS_EN
    , .pkt_count(pkt_count), .beat_count(beat_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dest;
    logic [1:0]  id;
    logic [1:0]  user;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  beat_t cur_b;
  assign cur_b = {m_axis_tdata, m_axis_tdest, m_axis_tid, m_axis_tuser, m_axis_tlast};

  int checks = 0, errs = 0;
  int mchecks = 0, merrs = 0;

  // Monitor: compare every handshake and require outputs frozen under backpressure
  initial begin
    beat_t prev;
    bit    hold;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          mchecks++;
          if (cur_b !== prev) begin
            merrs++;
            $display("FAIL hold_stable: got %h required %h", cur_b, prev);
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          mchecks++;
          if (exp_q.size() == 0) begin
            merrs++;
            $display("FAIL unexpected_beat: got %h required none", cur_b);
          end else begin
            if (cur_b !== exp_q[0]) begin
              merrs++;
              $display("FAIL beat: got %h required %h", cur_b, exp_q[0]);
            end
            void'(exp_q.pop_front());
          end
        end
        hold = m_axis_tvalid && !m_axis_tready;
        prev = cur_b;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    wr_en = 1'b1;
    wr_data = w;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic exp_beat(input logic [15:0] d, input logic [3:0] de,
                          input logic [1:0] i, input logic [1:0] u, input logic l);
    beat_t b;
    b = {d, de, i, u, l};
    exp_q.push_back(b);
  endtask

  // Returns right after the edge that accepted the descriptor
  task automatic send_desc(input logic [3:0] de, input logic [1:0] i,
                           input logic [1:0] u, input logic [7:0] l);
    bit ok;
    ok = 1'b0;
    desc_valid = 1'b1;
    desc_dest = de; desc_id = i; desc_user = u; desc_len = l;
    for (int n = 0; n < 200; n++) begin
      if (desc_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    desc_valid = 1'b0;
    chk("desc_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic drain(input string nm, input int max);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < max; n++) begin
      if (exp_q.size() == 0 && !m_axis_tvalid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(nm, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_tvalid", {31'd0, m_axis_tvalid}, 0);
    chk("rst_tlast", {31'd0, m_axis_tlast}, 0);
    chk("rst_tdata", {16'd0, m_axis_tdata}, 0);
    chk("rst_tdest", {28'd0, m_axis_tdest}, 0);
    chk("rst_tid", {30'd0, m_axis_tid}, 0);
    chk("rst_tuser", {30'd0, m_axis_tuser}, 0);
    chk("rst_desc_ready", {31'd0, desc_ready}, 0);
    chk("rst_wr_full", {31'd0, wr_full}, 0);
    chk("rst_level", {25'd0, fifo_level}, 0);
    chk("rst_err", {31'd0, err_overflow}, 0);
    rst = 1'b0;
    tick();
    chk("rdy_after_rst", {31'd0, desc_ready}, 1);

    // Single-beat packet
    m_axis_tready = 1'b1;
    push_word(16'hA5A5);
    exp_beat(16'hA5A5, 4'h8, 2'd1, 2'd3, 1'b1);
    send_desc(4'b1000, 2'b01, 2'b11, 8'd0);
    tick();
    chk("sb_tvalid", {31'd0, m_axis_tvalid}, 1);
    chk("sb_tdata", {16'd0, m_axis_tdata}, 32'hA5A5);
    chk("sb_tdest", {28'd0, m_axis_tdest}, 8);
    chk("sb_tid", {30'd0, m_axis_tid}, 1);
    chk("sb_tuser", {30'd0, m_axis_tuser}, 3);
    chk("sb_tlast", {31'd0, m_axis_tlast}, 1);
    chk("sb_rdy_busy", {31'd0, desc_ready}, 0);
    tick();
    chk("sb_rdy_again", {31'd0, desc_ready}, 1);
    chk("sb_tvalid_off", {31'd0, m_axis_tvalid}, 0);

    // Backpressure: first beat held three cycles, then full rate
    m_axis_tready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push_word(16'(k));
      exp_beat(16'(k), 4'h4, 2'd2, 2'd1, k == 3);
    end
    send_desc(4'h4, 2'd2, 2'd1, 8'd3);
    tick();
    chk("bp_first_valid", {31'd0, m_axis_tvalid}, 1);
    tick();
    tick();
    chk("bp_held_valid", {31'd0, m_axis_tvalid}, 1);
    chk("bp_held_data", {16'd0, m_axis_tdata}, 0);
    m_axis_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_consec_valid", {31'd0, m_axis_tvalid}, 1);
      chk("bp_consec_data", {16'd0, m_axis_tdata}, k);
      chk("bp_consec_last", {31'd0, m_axis_tlast}, (k == 3) ? 1 : 0);
      tick();
    end
    chk("bp_end_valid", {31'd0, m_axis_tvalid}, 0);

    // Underflow bubble mid-packet
    push_word(16'd10);
    push_word(16'd11);
    for (int k = 10; k < 14; k++) exp_beat(16'(k), 4'h2, 2'd3, 2'd0, k == 13);
    send_desc(4'h2, 2'd3, 2'd0, 8'd3);
    repeat (3) tick();
    chk("uf_bubble", {31'd0, m_axis_tvalid}, 0);
    repeat (2) tick();
    chk("uf_bubble_hold", {31'd0, m_axis_tvalid}, 0);
    chk("uf_rdy_busy", {31'd0, desc_ready}, 0);
    push_word(16'd12);
    push_word(16'd13);
    drain("uf_drain", 20);
    chk("uf_rdy_done", {31'd0, desc_ready}, 1);

    // Overflow: 65 pushes into a 64-deep FIFO, last one dropped
    m_axis_tready = 1'b0;
    for (int i = 0; i <= 64; i++) begin
      wr_en = 1'b1;
      wr_data = 16'(i);
      tick();
      if (i == 62) begin
        chk("of_level63", {25'd0, fifo_level}, 63);
        chk("of_notfull63", {31'd0, wr_full}, 0);
      end
      if (i == 63) begin
        chk("of_full", {31'd0, wr_full}, 1);
        chk("of_level64", {25'd0, fifo_level}, 64);
        chk("of_err_clear", {31'd0, err_overflow}, 0);
      end
    end
    wr_en = 1'b0;
    chk("of_err_set", {31'd0, err_overflow}, 1);
    chk("of_level_cap", {25'd0, fifo_level}, 64);
    for (int k = 0; k < 64; k++) exp_beat(16'(k), 4'hF, 2'd0, 2'd2, k == 63);
    send_desc(4'hF, 2'd0, 2'd2, 8'd63);
    m_axis_tready = 1'b1;
    drain("of_drain", 200);
    chk("of_err_sticky", {31'd0, err_overflow}, 1);
    chk("of_level_empty", {25'd0, fifo_level}, 0);
    chk("of_notfull", {31'd0, wr_full}, 0);

    // Reset mid-packet after the fourth beat handshakes
    for (int k = 0; k < 8; k++) push_word(16'(20 + k));
    for (int k = 0; k < 4; k++) exp_beat(16'(20 + k), 4'h5, 2'd1, 2'd2, 1'b0);
    send_desc(4'h5, 2'd1, 2'd2, 8'd7);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("mr_tvalid", {31'd0, m_axis_tvalid}, 0);
    chk("mr_tlast", {31'd0, m_axis_tlast}, 0);
    chk("mr_level", {25'd0, fifo_level}, 0);
    chk("mr_rdy", {31'd0, desc_ready}, 0);
    chk("mr_beats_seen", exp_q.size(), 0);
    rst = 1'b0;
    tick();
    chk("mr_rdy_after", {31'd0, desc_ready}, 1);
    chk("mr_err_cleared", {31'd0, err_overflow}, 0);

    // Two packets with two stall cycles
    push_word(16'h0100);
    exp_beat(16'h0100, 4'h1, 2'd1, 2'd1, 1'b1);
    send_desc(4'h1, 2'd1, 2'd1, 8'd0);
    drain("st_drain1", 20);
    for (int k = 0; k < 4; k++) begin
      push_word(16'h0200 + 16'(k));
      exp_beat(16'h0200 + 16'(k), 4'h3, 2'd0, 2'd0, k == 3);
    end
    m_axis_tready = 1'b0;
    send_desc(4'h3, 2'd0, 2'd0, 8'd3);
    tick();
    tick();
    tick();
    m_axis_tready = 1'b1;
    drain("st_drain2", 20);
    tick();
`ifdef AXIS_TX_STATS_EN
    chk("st_pkt", pkt_count, 2);
    chk("st_beat", beat_count, 5);
    chk("st_stall", stall_count, 2);
`endif
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks + mchecks, errs + merrs);
    $finish;
  end
endmodule

// File: doc/axis_packet_tx.md
Name: axis_packet_tx

Overview:
- AXI4-Stream packet transmitter: the source that drives one slave port of the stream interconnect.
- Producer logic pushes data words into an internal FIFO and issues one descriptor per packet (dest, id, user, length).
- Block emits the packet as AXI4-Stream beats, with TDEST/TID/TUSER constant per packet and TLAST on the final beat, and obeys TREADY backpressure.

Parameters:
DATA_WIDTH, 2, data width in bytes; tdata is DATA_WIDTH*8 bits
TDEST_WIDTH, 4, tdest width; interconnect routes on the upper 2 bits
TID_WIDTH, 2, tid width
TUSER_WIDTH, 2, tuser width
BUFFER_DEPTH, 64, data FIFO depth in words (power of 2)
LEN_WIDTH, 8, descriptor length field width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
wr_en  in  1  push wr_data into FIFO
wr_data  in  DATA_WIDTH*8  data word
wr_full  out  1  FIFO holds BUFFER_DEPTH words
fifo_level  out  $clog2(BUFFER_DEPTH+1)  current FIFO occupancy
err_overflow  out  1  sticky; set when a push is dropped while full
desc_valid  in  1  descriptor valid
desc_ready  out  1  descriptor accepted when valid&ready
desc_dest  in  TDEST_WIDTH  packet tdest
desc_id  in  TID_WIDTH  packet tid
desc_user  in  TUSER_WIDTH  packet tuser
desc_len  in  LEN_WIDTH  beats minus 1 (0 = single beat)
m_axis_tdata  out  DATA_WIDTH*8  stream data
m_axis_tdest  out  TDEST_WIDTH  stream dest
m_axis_tid  out  TID_WIDTH  stream id
m_axis_tuser  out  TUSER_WIDTH  stream user
m_axis_tvalid  out  1  beat valid
m_axis_tlast  out  1  final beat of packet
m_axis_tready  in  1  downstream ready

Behaviour:
- Single clock domain `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - all m_axis_* outputs 0, desc_ready 0, wr_full 0, fifo_level 0, err_overflow 0;
  - FIFO emptied, FSM in IDLE.
  - desc_ready rises the cycle after rst deasserts.
- FIFO:
  - Push when wr_en and not full.
  - wr_en while full: word dropped, err_overflow set. A dropped push stays dropped even if a pop occurs the same cycle.
  - Pop and push in the same cycle when not full: level unchanged.
  - No empty bypass: a word pushed in cycle N is poppable in cycle N+1.
  - Pointers wrap modulo BUFFER_DEPTH.
- FSM IDLE:
  - desc_ready=1.
  - On desc_valid&desc_ready: latch dest/id/user/len, clear beat counter, go to SEND.
- FSM SEND:
  - desc_ready=0. The output stage is a single register.
  - Load condition: register empty (tvalid=0) or handshake this cycle (tvalid&tready), AND FIFO not empty, AND beats still owed.
  - On load: pop FIFO into tdata, assert tvalid, set tlast when the beat count equals len, increment the count.
  - Earliest first tvalid is the cycle after descriptor acceptance, provided FIFO data is present.
  - Handshake with no load possible: tvalid drops to 0. Mid-packet underflow bubbles are legal.
  - While tvalid=1 and tready=0, all m_axis_* outputs are held stable (AXI rule).
  - tdest/tid/tuser equal the latched descriptor for every beat.
  - Handshake on a beat with tlast=1: go to IDLE, tvalid=0 next cycle. This gives one idle cycle between back-to-back packets.
- Full throughput: one beat per cycle while FIFO non-empty and tready=1.
- Beat counter width is LEN_WIDTH+1, so len=2^LEN_WIDTH-1 (256 beats) does not overflow.
- Reset mid-packet:
  - packet abandoned without tlast; FIFO contents discarded;
  - tvalid=0 the following cycle.
- Data is never reordered, duplicated or lost, except for dropped overflow pushes.

Optional Feature:
- Macro AXIS_TX_STATS_EN.
- When defined, adds three outputs, all reset to 0 and wrapping modulo 2^32:
  - pkt_count out 32: increments on each tlast handshake.
  - beat_count out 32: increments on each tvalid&tready.
  - stall_count out 32: increments each cycle tvalid&!tready.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single beat: push 16'hA5A5, then descriptor dest=4'b1000 id=2'b01 user=2'b11 len=0, tready=1 -> next cycle tvalid=1, tdata=A5A5, tdest=8, tid=1, tuser=3, tlast=1; desc_ready=1 again after the handshake.
- Backpressure: push 0,1,2,3; descriptor len=3; tready=0 for 3 cycles then 1 -> beat 0 held stable for 3 cycles; then beats 0,1,2,3 on consecutive cycles; tlast only on 3.
- Underflow bubble: descriptor len=3, only words 10,11 pushed -> two beats, then tvalid=0; push 12,13 -> beats resume, tlast on 13.
- Overflow: tready=0, push 65 words 0..64 -> wr_full=1 and fifo_level=64 after word 63; word 64 dropped; err_overflow=1 and stays 1 until rst.
- Reset mid-packet: len=7, assert rst after beat 3 handshake -> next cycle tvalid=0, fifo_level=0, desc_ready=0; desc_ready=1 the cycle after rst falls.
- AXIS_TX_STATS_EN: two packets (len=0, len=3) with 2 stall cycles -> pkt_count=2, beat_count=5, stall_count=2.
